bp_update_sched: RTL and testbench
==================================

# bp_update_sched

Predictor-update scheduler between the branch unit's resolution output and the frontend BHT/BTB update ports. Resolved branches are filtered by control-flow type and buffered in a small in-order queue, then drained one per cycle through a valid/ready handshake to whichever predictor table owns the entry. This decouples branch resolution from predictor write-port availability. Predictor updates are hints, so when the queue is full an entry is dropped and flagged instead of stalling the branch unit.

## Interface
- DEPTH, default 4: queue entries; power of two, minimum 2.
- VLEN, default 39: virtual address width.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush; empties the queue.
- res_valid_i  in  1  resolved branch valid; one-cycle pulse per branch.
- res_pc_i  in  VLEN  PC of the resolved instruction.
- res_target_i  in  VLEN  resolved target address.
- res_taken_i  in  1  branch outcome.
- res_mispredict_i  in  1  prediction was wrong.
- res_cf_i  in  3  cf_type encoding: NoCF=0, Branch=1, Jump=2, JumpR=3, Return=4.
- bht_valid_o  out  1  BHT update valid.
- bht_pc_o  out  VLEN  BHT update PC.
- bht_taken_o  out  1  BHT update outcome.
- bht_ready_i  in  1  BHT accepts the update.
- btb_valid_o  out  1  BTB update valid.
- btb_pc_o  out  VLEN  BTB update PC.
- btb_target_o  out  VLEN  BTB update target.
- btb_ready_i  in  1  BTB accepts the update.
- drop_o  out  1  registered pulse: last cycle's resolution was discarded because the queue was full.
- count_o  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Filter on res_valid_i:
  - cf=Branch: enqueue with dest=BHT.
  - cf=JumpR with res_mispredict_i=1: enqueue with dest=BTB.
  - Everything else: ignored. Ignored entries do not set drop_o.
- Entry fields: pc, target, taken, dest.
- Queue is a circular buffer:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - A separate counter distinguishes full from empty.
- Head presentation:
  - count_o>0 and head.dest=BHT: bht_valid_o=1, btb_valid_o=0.
  - count_o>0 and head.dest=BTB: btb_valid_o=1, bht_valid_o=0.
  - The two valids are never high together.
  - Data outputs are driven from the head entry. They are zero when the queue is empty.
- Dequeue happens when the presented valid and its matching ready are both high. A ready on the non-selected port has no effect.
- Strict in-order drain: a BTB-bound head blocks BHT-bound entries behind it, and vice versa.
- Enqueue is accepted when count_o<DEPTH, or when count_o=DEPTH and a dequeue occurs in the same cycle.
  - Otherwise the entry is dropped and drop_o=1 on the next cycle.
  - drop_o is 0 in all other cycles.
- Flush:
  - flush_i=1: next cycle count_o=0, both valids 0, pointers reset.
  - An enqueue presented in the same cycle is discarded, with drop_o=0.
  - A handshake in the same cycle completes, but its entry is discarded anyway.
  - Flush has priority over enqueue and dequeue.

## Timing
- Reset values: all valids 0, all data outputs 0, drop_o=0, count_o=0, pointers 0.
- Reset mid-operation discards all entries on the next edge.
- Latency: an enqueue into an empty queue presents the entry on the cycle after res_valid_i. There is no combinational path from res_* to the outputs.
- Throughput: one enqueue and one dequeue per cycle. Occupancy is unchanged when both happen.
- Stability: while a valid is high and its ready is low, the valid and all data outputs hold. flush_i and rst_i are the only exceptions.
- Ready signals may depend combinationally on valid; valid must not depend on ready.
- count_o is registered and updates on the edge after an enqueue or dequeue.

## Configuration
- Macro: BP_UPD_COALESCE_EN.
- Defined:
  - An accepted enqueue whose pc and dest match the tail entry overwrites the tail's taken/target fields instead of allocating a new entry. count_o is unchanged.
  - Coalescing applies only when count_o>=2, so the tail is never the presented head and the head's outputs stay stable.
  - A coalesced update never drops, even when the queue is full.
- Undefined: every accepted entry allocates a new slot; no PC comparators are synthesised.

## Test plan
- Single Branch: pc=0x80000010, taken=1, bht_ready_i=1 → bht_valid_o=1 on the cycle after res_valid_i with bht_pc_o=0x80000010, bht_taken_o=1; count_o returns to 0 on the following cycle.
- JumpR mispredict (pc=0x100, target=0x2000) enqueued behind a BHT entry, bht_ready_i=0 for 3 cycles → BHT outputs held stable; btb_valid_o stays 0 until the BHT handshake, then btb_target_o=0x2000.
- Both readies tied 0, 5 Branch resolutions with DEPTH=4 → count_o=4, drop_o=1 exactly once; the first 4 PCs later drain in order.
- Queue full, bht_ready_i=1 together with a new enqueue → no drop, count_o stays 4.
- Queue holds 3 entries, flush_i and res_valid_i asserted together → next cycle count_o=0, both valids 0, drop_o=0. Also assert rst_i mid-drain → the same empty state.
- With BP_UPD_COALESCE_EN: readies 0, enqueue pc=0x40 (taken=0), pc=0x80, then pc=0x80 (taken=1) → count_o=2; drain gives 0x40 with taken=0, then 0x80 with taken=1. Without the macro → count_o=3.

Source files
------------

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : bp_update_sched
// Description : Predictor-update scheduler. Filters resolved branches by
//               control-flow type and queues them in order. It drains one entry
//               per cycle to the BHT or BTB update port through valid/ready.
//               When the queue is full, the new update is dropped and flagged
//               on drop_o, so the branch unit never stalls.
//               Optional feature macro: BP_UPD_COALESCE_EN (tail coalescing of
//               repeated updates to the same PC and table).
// Revision    : 1.0 - initial release
// ============================================================================
module bp_update_sched #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       res_valid_i,
    input  logic [VLEN-1:0]            res_pc_i,
    input  logic [VLEN-1:0]            res_target_i,
    input  logic                       res_taken_i,
    input  logic                       res_mispredict_i,
    input  logic [2:0]                 res_cf_i,
    output logic                       bht_valid_o,
    output logic [VLEN-1:0]            bht_pc_o,
    output logic                       bht_taken_o,
    input  logic                       bht_ready_i,
    output logic                       btb_valid_o,
    output logic [VLEN-1:0]            btb_pc_o,
    output logic [VLEN-1:0]            btb_target_o,
    input  logic                       btb_ready_i,
    output logic                       drop_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int         c_PTR_W     = $clog2(DEPTH);
    localparam int         c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [2:0] c_CF_BRANCH = 3'd1;
    localparam logic [2:0] c_CF_JUMPR  = 3'd3;
    localparam logic       c_DEST_BTB  = 1'b1;

    // Queue storage: one slot per entry, dest bit 0 = BHT, 1 = BTB
    logic [VLEN-1:0]    r_pc     [DEPTH];
    logic [VLEN-1:0]    r_target [DEPTH];
    logic [DEPTH-1:0]   r_taken;
    logic [DEPTH-1:0]   r_dest;

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_drop;

    logic               w_head_vld;
    logic               w_head_dest;
    logic               w_deq;
    logic               w_enq_req;
    logic               w_enq_dest;
    logic               w_full;
    logic               w_coal;
    logic               w_alloc;
    logic               w_drop;

    // Head presentation comes only from registered state, never from res_*
    assign w_head_vld  = (r_count != '0);
    assign w_head_dest = r_dest[r_rd_ptr];

    assign bht_valid_o  = w_head_vld & (w_head_dest != c_DEST_BTB);
    assign btb_valid_o  = w_head_vld & (w_head_dest == c_DEST_BTB);
    assign bht_pc_o     = bht_valid_o ? r_pc[r_rd_ptr]     : '0;
    assign bht_taken_o  = bht_valid_o ? r_taken[r_rd_ptr]  : 1'b0;
    assign btb_pc_o     = btb_valid_o ? r_pc[r_rd_ptr]     : '0;
    assign btb_target_o = btb_valid_o ? r_target[r_rd_ptr] : '0;

    // Only the ready of the port that owns the head can pop it
    assign w_deq = (bht_valid_o & bht_ready_i) | (btb_valid_o & btb_ready_i);

    // Conditional branches train the BHT; only mispredicted indirect jumps
    // train the BTB. Everything else is silently ignored.
    assign w_enq_dest = (res_cf_i == c_CF_JUMPR);
    assign w_enq_req  = res_valid_i &
                        ((res_cf_i == c_CF_BRANCH) |
                         ((res_cf_i == c_CF_JUMPR) & res_mispredict_i));
    assign w_full     = (r_count == c_CNT_W'(DEPTH));

`ifdef BP_UPD_COALESCE_EN
    logic [c_PTR_W-1:0] w_tail_ptr;
    assign w_tail_ptr = r_wr_ptr - c_PTR_W'(1);
    // With two or more entries, the tail is never the presented head, so
    // rewriting the tail cannot disturb the outputs
    assign w_coal = w_enq_req && (r_count >= c_CNT_W'(2)) &&
                    (r_pc[w_tail_ptr] == res_pc_i) &&
                    (r_dest[w_tail_ptr] == w_enq_dest);
`else
    assign w_coal = 1'b0;
`endif

    // A dequeue in the same cycle frees a slot for a full-queue enqueue
    assign w_alloc = w_enq_req & ~w_coal & (~w_full | w_deq);
    assign w_drop  = w_enq_req & ~w_coal & w_full & ~w_deq;

    // Pointer, occupancy and drop-flag control; flush outranks enqueue/dequeue
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_alloc, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_drop <= w_drop;
        end
    end

    // Entry payload writes; stale slots are never presented, so no reset needed
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (w_alloc) begin
                r_pc[r_wr_ptr]     <= res_pc_i;
                r_target[r_wr_ptr] <= res_target_i;
                r_taken[r_wr_ptr]  <= res_taken_i;
                r_dest[r_wr_ptr]   <= w_enq_dest;
            end
`ifdef BP_UPD_COALESCE_EN
            if (w_coal) begin
                r_target[w_tail_ptr] <= res_target_i;
                r_taken[w_tail_ptr]  <= res_taken_i;
            end
`endif
        end
    end

    assign drop_o  = r_drop;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_update_sched
// Description : Self-checking bench for bp_update_sched. It applies a table of
//               per-cycle stimulus records with expected count/drop values, and
//               a queue model checks every presented head entry. It also runs
//               hand-written reset and coalescing sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_update_sched;

    localparam int DEPTH = 4;
    localparam int VLEN  = 39;

`ifdef BP_UPD_COALESCE_EN
    localparam int c_COAL_CNT = 2;
`else
    localparam int c_COAL_CNT = 3;
`endif

    typedef struct {
        logic            vld;
        logic [2:0]      cf;
        logic            misp;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] tgt;
        logic            tkn;
        logic            bry;
        logic            try;
        logic            fl;
        logic            rst;
        int              ecnt;
        logic            edrop;
    } vec_t;

    typedef struct {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] tgt;
        logic            tkn;
        logic            dest;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            res_valid_i;
    logic [VLEN-1:0] res_pc_i;
    logic [VLEN-1:0] res_target_i;
    logic            res_taken_i;
    logic            res_mispredict_i;
    logic [2:0]      res_cf_i;
    logic            bht_valid_o;
    logic [VLEN-1:0] bht_pc_o;
    logic            bht_taken_o;
    logic            bht_ready_i;
    logic            btb_valid_o;
    logic [VLEN-1:0] btb_pc_o;
    logic [VLEN-1:0] btb_target_o;
    logic            btb_ready_i;
    logic            drop_o;
    logic [2:0]      count_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t sb[$];
    vec_t tbl[$];

    bp_update_sched #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .res_valid_i      (res_valid_i),
        .res_pc_i         (res_pc_i),
        .res_target_i     (res_target_i),
        .res_taken_i      (res_taken_i),
        .res_mispredict_i (res_mispredict_i),
        .res_cf_i         (res_cf_i),
        .bht_valid_o      (bht_valid_o),
        .bht_pc_o         (bht_pc_o),
        .bht_taken_o      (bht_taken_o),
        .bht_ready_i      (bht_ready_i),
        .btb_valid_o      (btb_valid_o),
        .btb_pc_o         (btb_pc_o),
        .btb_target_o     (btb_target_o),
        .btb_ready_i      (btb_ready_i),
        .drop_o           (drop_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [2:0] cf, input logic misp,
                                input logic [VLEN-1:0] pc, input logic [VLEN-1:0] tgt,
                                input logic tkn, input logic bry, input logic try,
                                input logic fl, input logic rst, input int ecnt,
                                input logic edrop);
        vec_t v;
        v.vld = vld; v.cf = cf; v.misp = misp; v.pc = pc; v.tgt = tgt; v.tkn = tkn;
        v.bry = bry; v.try = try; v.fl = fl; v.rst = rst; v.ecnt = ecnt; v.edrop = edrop;
        return v;
    endfunction

    function automatic vec_t idle(input logic bry, input logic try, input int ecnt);
        return mk(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, bry, try, 1'b0, 1'b0, ecnt, 1'b0);
    endfunction

    function automatic vec_t br(input logic [VLEN-1:0] pc, input logic tkn, input logic bry,
                                input int ecnt, input logic edrop);
        return mk(1'b1, 3'd1, 1'b0, pc, '0, tkn, bry, 1'b0, 1'b0, 1'b0, ecnt, edrop);
    endfunction

    // Compare the presented head against the model's oldest entry
    task automatic check_present(input string name);
        if (sb.size() == 0) begin
            chk({name, "_empty_valids"}, {62'd0, bht_valid_o, btb_valid_o}, 64'd0);
            chk({name, "_empty_data"}, {24'd0, bht_pc_o | btb_pc_o | btb_target_o, bht_taken_o}, 64'd0);
        end else if (sb[0].dest == 1'b0) begin
            chk({name, "_bht_valids"}, {62'd0, bht_valid_o, btb_valid_o}, 64'd2);
            chk({name, "_bht_data"}, {24'd0, bht_pc_o, bht_taken_o}, {24'd0, sb[0].pc, sb[0].tkn});
        end else begin
            chk({name, "_btb_valids"}, {62'd0, bht_valid_o, btb_valid_o}, 64'd1);
            chk({name, "_btb_pc"}, {25'd0, btb_pc_o}, {25'd0, sb[0].pc});
            chk({name, "_btb_target"}, {25'd0, btb_target_o}, {25'd0, sb[0].tgt});
        end
    endtask

    // One clock cycle: drive, check the head mid-cycle, update the model, check count/drop
    task automatic step(input vec_t v, input string name);
        logic enq_req;
        logic dest;
        logic deq;
        logic coal;
        int   n;
        ent_t e;
        rst_i            = v.rst;
        flush_i          = v.fl;
        res_valid_i      = v.vld;
        res_cf_i         = v.cf;
        res_mispredict_i = v.misp;
        res_pc_i         = v.pc;
        res_target_i     = v.tgt;
        res_taken_i      = v.tkn;
        bht_ready_i      = v.bry;
        btb_ready_i      = v.try;
        @(negedge clk);
        check_present(name);
        n       = sb.size();
        dest    = (v.cf == 3'd3);
        enq_req = v.vld && ((v.cf == 3'd1) || (v.cf == 3'd3 && v.misp));
        deq     = (n > 0) && ((sb[0].dest == 1'b0) ? v.bry : v.try);
        coal    = 1'b0;
`ifdef BP_UPD_COALESCE_EN
        if (enq_req && n >= 2 && sb[n-1].pc == v.pc && sb[n-1].dest == dest) coal = 1'b1;
`endif
        if (deq) void'(sb.pop_front());
        if (v.rst || v.fl) begin
            sb.delete();
        end else if (coal) begin
            sb[sb.size()-1].tkn = v.tkn;
            sb[sb.size()-1].tgt = v.tgt;
        end else if (enq_req && (n < DEPTH || deq)) begin
            e.pc = v.pc; e.tgt = v.tgt; e.tkn = v.tkn; e.dest = dest;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({name, "_count"}, 64'(count_o), 64'(v.ecnt));
        chk({name, "_drop"}, {63'd0, drop_o}, {63'd0, v.edrop});
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; res_valid_i = 1'b0; res_cf_i = 3'd0;
        res_mispredict_i = 1'b0; res_pc_i = '0; res_target_i = '0; res_taken_i = 1'b0;
        bht_ready_i = 1'b0; btb_ready_i = 1'b0;

        // Single branch, latency and return to empty
        tbl.push_back(br(39'h80000010, 1'b1, 1'b1, 1, 1'b0));
        tbl.push_back(idle(1'b1, 1'b0, 0));
        // JumpR mispredict behind a stalled BHT entry; BTB ready ignored while BHT owns head
        tbl.push_back(br(39'h200, 1'b0, 1'b0, 1, 1'b0));
        tbl.push_back(mk(1'b1, 3'd3, 1'b1, 39'h100, 39'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0));
        tbl.push_back(idle(1'b0, 1'b1, 2));
        tbl.push_back(idle(1'b0, 1'b0, 2));
        tbl.push_back(idle(1'b1, 1'b0, 1));
        tbl.push_back(idle(1'b0, 1'b1, 0));
        // Filtered-out types: Jump, predicted JumpR, Return, NoCF
        tbl.push_back(mk(1'b1, 3'd2, 1'b1, 39'h300, 39'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        tbl.push_back(mk(1'b1, 3'd3, 1'b0, 39'h310, 39'h410, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        tbl.push_back(mk(1'b1, 3'd4, 1'b1, 39'h320, 39'h420, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        tbl.push_back(mk(1'b1, 3'd0, 1'b1, 39'h330, 39'h430, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        // Fill past capacity: exactly one drop
        tbl.push_back(br(39'h10, 1'b1, 1'b0, 1, 1'b0));
        tbl.push_back(br(39'h20, 1'b0, 1'b0, 2, 1'b0));
        tbl.push_back(br(39'h30, 1'b1, 1'b0, 3, 1'b0));
        tbl.push_back(br(39'h40, 1'b0, 1'b0, 4, 1'b0));
        tbl.push_back(br(39'h50, 1'b1, 1'b0, 4, 1'b1));
        tbl.push_back(idle(1'b0, 1'b0, 4));
        // Full queue with simultaneous dequeue and enqueue: no drop
        tbl.push_back(br(39'h60, 1'b1, 1'b1, 4, 1'b0));
        tbl.push_back(idle(1'b1, 1'b0, 3));
        tbl.push_back(idle(1'b1, 1'b0, 2));
        tbl.push_back(idle(1'b1, 1'b0, 1));
        tbl.push_back(idle(1'b1, 1'b0, 0));
        // Flush with concurrent enqueue and handshake
        tbl.push_back(br(39'hA0, 1'b1, 1'b0, 1, 1'b0));
        tbl.push_back(br(39'hB0, 1'b0, 1'b0, 2, 1'b0));
        tbl.push_back(mk(1'b1, 3'd3, 1'b1, 39'hC0, 39'hC00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0));
        tbl.push_back(mk(1'b1, 3'd1, 1'b0, 39'hD0, 39'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0));
        tbl.push_back(idle(1'b1, 1'b1, 0));

        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_drop", {63'd0, drop_o}, 64'd0);
        check_present("reset");
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a drain, with a concurrent enqueue
        step(br(39'h300, 1'b1, 1'b0, 1, 1'b0), "rst_fill0");
        step(br(39'h310, 1'b0, 1'b0, 2, 1'b0), "rst_fill1");
        step(br(39'h320, 1'b1, 1'b0, 3, 1'b0), "rst_fill2");
        step(idle(1'b1, 1'b0, 2), "rst_drain");
        step(mk(1'b1, 3'd1, 1'b0, 39'h330, 39'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0), "rst_mid");
        step(idle(1'b1, 1'b1, 0), "rst_after");

        // Tail coalescing of a repeated PC (3 entries when the feature is off)
        step(br(39'h40, 1'b0, 1'b0, 1, 1'b0), "coal0");
        step(br(39'h80, 1'b0, 1'b0, 2, 1'b0), "coal1");
        step(br(39'h80, 1'b1, 1'b0, c_COAL_CNT, 1'b0), "coal2");
        for (int k = c_COAL_CNT - 1; k >= 0; k--) begin
            step(idle(1'b1, 1'b0, k), $sformatf("coal_drain%0d", k));
        end
        step(idle(1'b0, 1'b0, 0), "final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
